// File: rtl/hello_pkg.sv
// Shared definitions for the hello-world beat sequencer: state encoding,
// default message length and the message text itself.
package hello_pkg;

  localparam int unsigned HELLO_LEN   = 14;
  localparam int unsigned MSG_LEN_DEF = HELLO_LEN;

  // Byte 0 sits in the most significant byte.
  localparam logic [8*HELLO_LEN-1:0] HELLO_MSG = {"Hello, world", 8'h0D, 8'h0A};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  // Message byte at position i; positions past the text read as zero.
  function automatic logic [7:0] msg_byte(input int unsigned i);
    logic [8*HELLO_LEN-1:0] w_sh;
    if (i >= HELLO_LEN) begin
      return 8'h00;
    end
    w_sh = HELLO_MSG << (8 * i);
    return w_sh[8*HELLO_LEN-1 -: 8];
  endfunction

endpackage

// File: rtl/hello_sequencer_if.sv
// Byte handshake between the sequencer and the UART transmitter.
interface hello_sequencer_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/hello_rom.sv
// Message ROM with a registered read port; the output only updates on a read.
module hello_rom
  import hello_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_addr,
  output logic [7:0]       o_data
);

  logic [7:0] r_data;

  // Registered lookup; holding the value keeps the offered byte stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= 8'h00;
    end else if (i_rd_en) begin
      r_data <= msg_byte(32'(i_addr));
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/hello_sequencer.sv
// Sends the message once per beat over a valid/ready byte handshake.
// One beat may be queued while a message is in flight; further beats are
// counted as dropped.
module hello_sequencer
  import hello_pkg::*;
#(
  parameter int unsigned MSG_LEN = MSG_LEN_DEF,
  parameter int unsigned IDX_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  hello_sequencer_if.master tx,
  output logic              busy,
  output logic              done,
  output logic [7:0]        dropped
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_pending;
  logic             r_tx_valid;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_dropped;

  logic             w_xfer;
  logic             w_rd_en;
  logic [7:0]       w_rom_data;

  assign w_xfer  = r_tx_valid & tx.tx_ready;
  assign w_rd_en = (r_state == ST_FETCH);

  hello_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .clk     (clk),
    .reset   (reset),
    .i_rd_en (w_rd_en),
    .i_addr  (r_idx),
    .o_data  (w_rom_data)
  );

  // Control FSM plus beat queueing; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= 8'h00;
    end else begin
      r_done <= 1'b0;

      // Beats during a message: queue one, count the rest.
      if (r_state != ST_IDLE && beat) begin
        if (!r_pending) begin
          r_pending <= 1'b1;
        end else if (r_dropped != 8'hFF) begin
          r_dropped <= r_dropped + 8'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (beat || r_pending) begin
            r_state   <= ST_FETCH;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            // A fresh beat alongside a queued one stays queued.
            r_pending <= beat & r_pending;
          end
        end
        ST_FETCH: begin
          r_state    <= ST_SEND;
          r_tx_valid <= 1'b1;
        end
        ST_SEND: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_IDLE;
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
              r_idx   <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_valid = r_tx_valid;
  assign tx.tx_data  = w_rom_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dropped     = r_dropped;

endmodule

// File: tb/tb_hello_sequencer.sv
// Self-checking bench for hello_sequencer: vector table, directed scenarios
// and a randomized run against a transaction-level reference model.
module tb_hello_sequencer;

  localparam int unsigned LEN = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       beat;
  logic       busy;
  logic       done;
  logic [7:0] dropped;

  hello_sequencer_if tx();

  hello_sequencer #(
    .MSG_LEN (LEN),
    .IDX_W   (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .beat    (beat),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] msg_b [LEN];
  logic [7:0] acc [$];
  int         done_cnt;
  int         busy_cnt;
  int         cyc_n;
  int         last_xfer;
  int         bad_gap;

  typedef struct {
    logic       b;
    logic       rdy;
    logic       v;
    logic [7:0] d;
    logic       bsy;
    logic       dn;
    logic [7:0] drp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; records accepted bytes, done pulses, busy cycles, byte spacing.
  task automatic cyc();
    logic       x;
    logic [7:0] d;
    x = tx.tx_valid && tx.tx_ready;
    d = tx.tx_data;
    @(posedge clk);
    #1;
    cyc_n++;
    if (x) begin
      acc.push_back(d);
      if (last_xfer >= 0 && (cyc_n - last_xfer) != 2) bad_gap++;
      last_xfer = cyc_n;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic clr();
    acc.delete();
    done_cnt  = 0;
    busy_cnt  = 0;
    cyc_n     = 0;
    last_xfer = -1;
    bad_gap   = 0;
  endtask

  task automatic do_reset();
    beat        = 1'b0;
    tx.tx_ready = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc();
    beat = 1'b0;
  endtask

  task automatic chk_bytes(input string nm, input int n);
    chk({nm, "_count"}, 32'(acc.size()), 32'(n));
    for (int i = 0; i < acc.size() && i < n; i++) begin
      chk($sformatf("%s_byte%0d", nm, i), 32'(acc[i]), 32'(msg_b[i % LEN]));
    end
  endtask

  // Run until the given byte position is on offer, with a cycle budget.
  task automatic wait_offer(input string nm, input int pos);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (tx.tx_valid && acc.size() == pos) found = 1'b1;
      else cyc();
    end
    chk({nm, "_reached"}, 32'(found), 32'd1);
  endtask

  // Reference model: bytes left in the current message, whether the next
  // byte is still a cycle away, the single queued beat, and the drop count.
  int m_left;
  bit m_gap;
  bit m_held;
  int m_drops;
  bit m_done;

  task automatic model_step(input bit b, input bit r);
    m_done = 1'b0;
    if (m_left == 0) begin
      if (b || m_held) begin
        m_left = LEN;
        m_gap  = 1'b1;
        m_held = b && m_held;
      end
    end else begin
      if (b) begin
        if (m_held) begin
          if (m_drops < 255) m_drops++;
        end else begin
          m_held = 1'b1;
        end
      end
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (r) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
        else             m_gap  = 1'b1;
      end
    end
  endtask

  initial begin
    msg_b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A};

    // {beat, ready} -> {valid, data, busy, done, dropped} after the edge
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h48, 1'b1, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h65, 1'b1, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h65, 1'b1, 1'b0, 8'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h65, 1'b1, 1'b0, 8'd0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h65, 1'b1, 1'b0, 8'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h6C, 1'b1, 1'b0, 8'd1};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h6C, 1'b1, 1'b0, 8'd1};

    // Reset values while reset is held
    beat        = 1'b0;
    tx.tx_ready = 1'b0;
    reset       = 1'b1;
    #12;
    chk("rst_valid",   32'(tx.tx_valid), 32'd0);
    chk("rst_data",    32'(tx.tx_data),  32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_done",    32'(done),        32'd0);
    chk("rst_dropped", 32'(dropped),     32'd0);
    do_reset();

    // Vector table
    for (int i = 0; i < 10; i++) begin
      beat        = tbl[i].b;
      tx.tx_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i),   32'(tx.tx_valid), 32'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("vec%0d_data", i), 32'(tx.tx_data), 32'(tbl[i].d));
      chk($sformatf("vec%0d_busy", i),    32'(busy),        32'(tbl[i].bsy));
      chk($sformatf("vec%0d_done", i),    32'(done),        32'(tbl[i].dn));
      chk($sformatf("vec%0d_dropped", i), 32'(dropped),     32'(tbl[i].drp));
    end

    // Single beat, ready tied high: full message, latency, spacing, busy time
    do_reset();
    tx.tx_ready = 1'b1;
    pulse_beat();
    chk("lat_fetch_valid", 32'(tx.tx_valid), 32'd0);
    cyc();
    chk("lat_first_valid", 32'(tx.tx_valid), 32'd1);
    chk("lat_first_data",  32'(tx.tx_data),  32'h48);
    repeat (38) cyc();
    chk_bytes("single", LEN);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_busy_cyc", 32'(busy_cnt), 32'd28);
    chk("single_spacing",  32'(bad_gap),  32'd0);

    // Stall for 5 cycles on byte 3
    do_reset();
    tx.tx_ready = 1'b1;
    pulse_beat();
    wait_offer("stall", 3);
    tx.tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("stall_valid%0d", k), 32'(tx.tx_valid), 32'd1);
      chk($sformatf("stall_data%0d", k),  32'(tx.tx_data),  32'h6C);
    end
    tx.tx_ready = 1'b1;
    repeat (40) cyc();
    chk_bytes("stall", LEN);
    chk("stall_done_cnt", 32'(done_cnt), 32'd1);

    // Beats at 0, 3 and 6 cycles into a message
    do_reset();
    tx.tx_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      beat = (t == 0 || t == 3 || t == 6);
      cyc();
    end
    beat = 1'b0;
    chk_bytes("queue", 2 * LEN);
    chk("queue_dropped",  32'(dropped),  32'd1);
    chk("queue_done_cnt", 32'(done_cnt), 32'd2);

    // Drop counter saturation with a stalled transmitter
    do_reset();
    for (int t = 0; t < 302; t++) begin
      beat = 1'b1;
      cyc();
      if (t == 99) chk("sat_mid", 32'(dropped), 32'd98);
    end
    beat = 1'b0;
    chk("sat_dropped", 32'(dropped), 32'd255);

    // Reset mid-message after five bytes accepted
    do_reset();
    tx.tx_ready = 1'b1;
    pulse_beat();
    wait_offer("midrst", 5);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid",   32'(tx.tx_valid), 32'd0);
    chk("midrst_data",    32'(tx.tx_data),  32'd0);
    chk("midrst_busy",    32'(busy),        32'd0);
    chk("midrst_done",    32'(done),        32'd0);
    chk("midrst_dropped", 32'(dropped),     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    repeat (10) cyc();
    chk("midrst_idle_busy", 32'(busy_cnt),    32'd0);
    chk("midrst_idle_xfer", 32'(acc.size()), 32'd0);
    pulse_beat();
    repeat (6) cyc();
    chk("midrst_restart_cnt", 32'(acc.size() >= 1), 32'd1);
    if (acc.size() >= 1) chk("midrst_restart_byte", 32'(acc[0]), 32'h48);

    // Beat coincident with the final transfer
    do_reset();
    tx.tx_ready = 1'b1;
    pulse_beat();
    wait_offer("last", LEN - 1);
    chk("last_data", 32'(tx.tx_data), 32'h0A);
    beat = 1'b1;
    cyc();
    beat = 1'b0;
    chk("last_done", 32'(done), 32'd1);
    repeat (40) cyc();
    chk_bytes("last", 2 * LEN);
    chk("last_dropped",  32'(dropped),  32'd0);
    chk("last_done_cnt", 32'(done_cnt), 32'd2);

    // Beat seen only while reset is high is ignored; after release it counts
    reset = 1'b1;
    beat  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    beat  = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_ignored", 32'(busy), 32'd0);
    reset = 1'b1;
    beat  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    beat = 1'b0;
    chk("rel_honoured", 32'(busy), 32'd1);

    // Randomized run against the reference model
    do_reset();
    m_left  = 0;
    m_gap   = 1'b0;
    m_held  = 1'b0;
    m_drops = 0;
    m_done  = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bit b;
      bit r;
      bit ev;
      b = ($urandom % 25) == 0;
      r = ($urandom % 4) != 0;
      beat        = b;
      tx.tx_ready = r;
      @(posedge clk);
      #1;
      model_step(b, r);
      ev = (m_left != 0) && !m_gap;
      chk($sformatf("rand%0d_ctl", c),
          {20'd0, tx.tx_valid, busy, done, 1'b0, dropped},
          {20'd0, ev, m_left != 0, m_done, 1'b0, 8'(m_drops)});
      if (ev) chk($sformatf("rand%0d_data", c), 32'(tx.tx_data), 32'(msg_b[LEN - m_left]));
    end
    beat        = 1'b0;
    tx.tx_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
